// File: rtl/mem_stage_sram.sv
// Memory stage: performs 32-bit loads/stores on a 16-bit asynchronous SRAM as two
// half-word accesses with programmable wait states, freezing the pipeline meanwhile.
module mem_stage_sram #(
  parameter int SRAM_AW     = 18,
  parameter int SRAM_DW     = 16,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        val_rm,
  input  logic [3:0]         dest_in,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic [31:0]        alu_out,
  output logic [3:0]         dest_out,
  output logic [31:0]        mem_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST   = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] PENULT = 4'(WAIT_CYCLES - 2);

  state_t               state;
  logic [3:0]           cnt;
  logic [SRAM_DW-1:0]   lo_buf;
  logic                 mem_op;
  logic                 is_read;
  logic                 last_beat;
  logic [31:0]          offset;
  logic [SRAM_AW-1:0]   lo_addr;
  logic [SRAM_AW-1:0]   hi_addr;

  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en;
  assign alu_out      = alu_result;
  assign dest_out     = dest_in;

  // A simultaneous read and write request is treated as a store.
  assign mem_op    = mem_r_en | mem_w_en;
  assign is_read   = mem_r_en & ~mem_w_en;
  assign last_beat = (cnt == LAST);

  assign offset  = alu_result - 32'(BASE_ADDR);
  assign lo_addr = SRAM_AW'({offset >> 2, 1'b0});
  assign hi_addr = lo_addr | SRAM_AW'(1);

  assign ready = ((state == IDLE) && !mem_op) || (state == DONE);

  // SRAM strobes are registered and set up one cycle ahead so they never glitch;
  // write enable releases on the final cycle of each phase while address/data hold.
  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lo_buf     <= '0;
      mem_data   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            state      <= LO;
            cnt        <= '0;
            sram_addr  <= lo_addr;
            sram_wdata <= mem_w_en ? val_rm[SRAM_DW-1:0] : '0;
            sram_we_n  <= ~mem_w_en;
            sram_oe_n  <= ~is_read;
          end
        end
        LO: begin
          if (last_beat) begin
            state      <= HI;
            cnt        <= '0;
            if (is_read) lo_buf <= sram_rdata;
            sram_addr  <= hi_addr;
            sram_wdata <= mem_w_en ? val_rm[2*SRAM_DW-1:SRAM_DW] : '0;
            sram_we_n  <= ~mem_w_en;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == PENULT) sram_we_n <= 1'b1;
          end
        end
        HI: begin
          if (last_beat) begin
            state      <= DONE;
            cnt        <= '0;
            if (is_read) mem_data <= {sram_rdata, lo_buf};
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == PENULT) sram_we_n <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Self-checking bench for mem_stage_sram: behavioural async SRAM, write/read scoreboards,
// and one task per scenario.
module tb_mem_stage_sram;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk, rst;
  logic        wb_en_in, mem_r_en, mem_w_en;
  logic [31:0] alu_result, val_rm;
  logic [3:0]  dest_in;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_out, mem_data;
  logic [3:0]  dest_out;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_we_n, sram_oe_n;

  mem_stage_sram #(.SRAM_AW(18), .SRAM_DW(16), .WAIT_CYCLES(5), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_result(alu_result), .val_rm(val_rm), .dest_in(dest_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_out(alu_out),
    .dest_out(dest_out), .mem_data(mem_data), .ready(ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM: a write lands when WE rises; an access cut short by reset is lost.
  logic [15:0] mem [0:15];
  wr_t         wlog [0:63];
  int          wr_n = 0;
  int          oe_low = 0;
  int          we_low [0:15];
  logic        pend_v = 1'b0;
  wr_t         pend;
  logic        poke_v = 1'b0;
  logic [3:0]  poke_a = '0;
  logic [15:0] poke_d = '0;

  initial for (int i = 0; i < 16; i++) we_low[i] = 0;

  assign sram_rdata = sram_oe_n ? 16'hxxxx : mem[sram_addr[3:0]];

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      pend_v <= 1'b0;
    end else begin
      if (poke_v) mem[poke_a] <= poke_d;
      if (!sram_oe_n) oe_low <= oe_low + 1;
      if (!sram_we_n) begin
        we_low[sram_addr[3:0]] <= we_low[sram_addr[3:0]] + 1;
        pend_v <= 1'b1;
        pend   <= '{a: sram_addr, d: sram_wdata};
      end else if (pend_v) begin
        mem[pend.a[3:0]] <= pend.d;
        wlog[wr_n]       <= pend;
        wr_n             <= wr_n + 1;
        pend_v           <= 1'b0;
      end
    end
  end

  int          passed = 0;
  int          total  = 0;
  int          rd_idx = 0;
  wr_t         exp_wr [$];
  logic [31:0] exp_rd [$];

  task automatic apply(input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
    mem_r_en   = r;
    mem_w_en   = w;
    alu_result = a;
    val_rm     = v;
  endtask

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    poke_v = 1'b1;
    poke_a = a;
    poke_d = d;
    @(negedge clk);
    #1;
    poke_v = 1'b0;
  endtask

  // Returns at the falling edge of the first cycle with ready high.
  task automatic wait_done(output int low, output logic timeout);
    low     = 0;
    timeout = 1'b0;
    forever begin
      @(negedge clk);
      if (ready) break;
      low++;
      if (low > 100) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    total++;
    if ({ready, sram_we_n, sram_oe_n} !== 3'b111) $display("FAIL reset_strobes: got %b expected 111", {ready, sram_we_n, sram_oe_n});
    else passed++;
    total++;
    if (sram_addr !== 18'd0) $display("FAIL reset_addr: got %h expected 0", sram_addr);
    else passed++;
    total++;
    if (sram_wdata !== 16'd0) $display("FAIL reset_wdata: got %h expected 0", sram_wdata);
    else passed++;
    total++;
    if (mem_data !== 32'd0) $display("FAIL reset_mem_data: got %h expected 0", mem_data);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough;
    logic [31:0] vals [4];
    vals[0] = 32'h55; vals[1] = 32'hFFFF_FFFF; vals[2] = 32'd1024; vals[3] = 32'h8000_0001;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, vals[i], 32'h1234_5678);
      wb_en_in = i[0];
      dest_in  = 4'(i + 7);
      @(negedge clk);
      total++;
      if ({ready, sram_we_n, sram_oe_n, alu_out, wb_en_out, mem_r_en_out, dest_out}
          !== {3'b111, vals[i], i[0], 1'b0, 4'(i + 7)})
        $display("FAIL passthrough[%0d]: got rdy=%b we=%b oe=%b alu=%h wb=%b dest=%h expected rdy=1 we=1 oe=1 alu=%h wb=%b dest=%h",
                 i, ready, sram_we_n, sram_oe_n, alu_out, wb_en_out, dest_out, vals[i], i[0], 4'(i + 7));
      else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_store;
    int low, we0, we1, oe0;
    logic to;
    wr_t e;
    we0 = we_low[0]; we1 = we_low[1]; oe0 = oe_low;
    exp_wr.push_back('{a: 18'd0, d: 16'hBEEF});
    exp_wr.push_back('{a: 18'd1, d: 16'hDEAD});
    apply(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
    wait_done(low, to);
    total++;
    if (to || low != 11) $display("FAIL store_latency: got %0d low cycles (timeout=%b) expected 11", low, to);
    else passed++;
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (ready !== 1'b1) $display("FAIL store_idle_ready: got %b expected 1", ready);
    else passed++;
    total++;
    if (we_low[0] - we0 != 4 || we_low[1] - we1 != 4)
      $display("FAIL store_we_width: got %0d/%0d expected 4/4", we_low[0] - we0, we_low[1] - we1);
    else passed++;
    total++;
    if (oe_low != oe0) $display("FAIL store_oe: got %0d oe cycles expected 0", oe_low - oe0);
    else passed++;
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front();
      total++;
      if (rd_idx >= wr_n) $display("FAIL store_write: got none expected %h", e);
      else if (wlog[rd_idx] !== e) $display("FAIL store_write: got %h expected %h", wlog[rd_idx], e);
      else passed++;
      rd_idx++;
    end
    total++;
    if (wr_n != rd_idx) $display("FAIL store_write_count: got %0d expected %0d", wr_n, rd_idx);
    else passed++;
    rd_idx = wr_n;
  endtask

  task automatic test_load;
    int low, oe0, w0;
    logic to;
    logic [31:0] e;
    poke(4'd2, 16'h1234);
    poke(4'd3, 16'hABCD);
    oe0 = oe_low; w0 = wr_n;
    exp_rd.push_back(32'hABCD_1234);
    @(posedge clk);
    #1;
    apply(1'b1, 1'b0, 32'd1028, 32'hFFFF_FFFF);
    @(negedge clk);
    total++;
    if (mem_r_en_out !== 1'b1 || ready !== 1'b0) $display("FAIL load_start: got r_out=%b ready=%b expected 1/0", mem_r_en_out, ready);
    else passed++;
    wait_done(low, to);
    total++;
    if (to || low != 10) $display("FAIL load_latency: got %0d further low cycles (timeout=%b) expected 10", low, to);
    else passed++;
    e = exp_rd.pop_front();
    total++;
    if (mem_data !== e) $display("FAIL load_data: got %h expected %h", mem_data, e);
    else passed++;
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || sram_oe_n !== 1'b1 || mem_data !== e)
      $display("FAIL load_after: got ready=%b oe_n=%b data=%h expected 1/1/%h", ready, sram_oe_n, mem_data, e);
    else passed++;
    total++;
    if (oe_low - oe0 != 10 || wr_n != w0)
      $display("FAIL load_strobes: got oe=%0d writes=%0d expected 10/0", oe_low - oe0, wr_n - w0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int low;
    logic to;
    logic [31:0] e;
    wr_t ew;
    poke(4'd4, 16'h4444);
    poke(4'd5, 16'h5555);
    exp_rd.push_back(32'h5555_4444);
    @(posedge clk);
    #1;
    apply(1'b1, 1'b0, 32'd1032, 32'h0);
    wait_done(low, to);
    e = exp_rd.pop_front();
    total++;
    if (to || mem_data !== e) $display("FAIL b2b_load: got %h (timeout=%b) expected %h", mem_data, to, e);
    else passed++;
    @(posedge clk);
    #1;
    exp_wr.push_back('{a: 18'd6, d: 16'h6666});
    exp_wr.push_back('{a: 18'd7, d: 16'h7777});
    apply(1'b0, 1'b1, 32'd1036, 32'h7777_6666);
    wait_done(low, to);
    total++;
    if (to || low != 11) $display("FAIL b2b_store_latency: got %0d (timeout=%b) expected 11", low, to);
    else passed++;
    total++;
    if (mem_data !== e) $display("FAIL b2b_mem_data_hold: got %h expected %h", mem_data, e);
    else passed++;
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    while (exp_wr.size() != 0) begin
      ew = exp_wr.pop_front();
      total++;
      if (rd_idx >= wr_n) $display("FAIL b2b_write: got none expected %h", ew);
      else if (wlog[rd_idx] !== ew) $display("FAIL b2b_write: got %h expected %h", wlog[rd_idx], ew);
      else passed++;
      rd_idx++;
    end
    total++;
    if (wr_n != rd_idx) $display("FAIL b2b_write_count: got %0d expected %0d", wr_n, rd_idx);
    else passed++;
    rd_idx = wr_n;
  endtask

  task automatic test_reset_mid_store;
    logic found;
    wr_t ew;
    poke(4'd1, 16'h5A5A);
    exp_wr.push_back('{a: 18'd0, d: 16'hF00D});
    @(posedge clk);
    #1;
    apply(1'b0, 1'b1, 32'd1024, 32'hCAFE_F00D);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sram_addr == 18'd1) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) $display("FAIL rst_mid_reach_hi: got no HI phase expected one");
    else passed++;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({sram_we_n, sram_oe_n, sram_addr, sram_wdata, mem_data} !== {2'b11, 18'd0, 16'd0, 32'd0})
      $display("FAIL rst_mid_outputs: got we=%b oe=%b addr=%h wd=%h md=%h expected 1/1/0/0/0",
               sram_we_n, sram_oe_n, sram_addr, sram_wdata, mem_data);
    else passed++;
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    total++;
    if (ready !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", ready);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1 || mem[1] !== 16'h5A5A)
      $display("FAIL rst_mid_after: got ready=%b hw1=%h expected 1/5a5a", ready, mem[1]);
    else passed++;
    while (exp_wr.size() != 0) begin
      ew = exp_wr.pop_front();
      total++;
      if (rd_idx >= wr_n) $display("FAIL rst_mid_write: got none expected %h", ew);
      else if (wlog[rd_idx] !== ew) $display("FAIL rst_mid_write: got %h expected %h", wlog[rd_idx], ew);
      else passed++;
      rd_idx++;
    end
    total++;
    if (wr_n != rd_idx) $display("FAIL rst_mid_write_count: got %0d expected %0d", wr_n, rd_idx);
    else passed++;
    rd_idx = wr_n;
  endtask

  task automatic test_read_write_both;
    int low, oe0;
    logic to;
    wr_t ew;
    oe0 = oe_low;
    exp_wr.push_back('{a: 18'd0, d: 16'h2468});
    exp_wr.push_back('{a: 18'd1, d: 16'h1357});
    apply(1'b1, 1'b1, 32'd1024, 32'h1357_2468);
    wait_done(low, to);
    total++;
    if (to || low != 11) $display("FAIL rw_latency: got %0d (timeout=%b) expected 11", low, to);
    else passed++;
    total++;
    if (mem_data !== 32'd0 || mem_r_en_out !== 1'b1)
      $display("FAIL rw_mem_data: got md=%h r_out=%b expected 0/1", mem_data, mem_r_en_out);
    else passed++;
    total++;
    if (oe_low != oe0) $display("FAIL rw_oe: got %0d oe cycles expected 0", oe_low - oe0);
    else passed++;
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    while (exp_wr.size() != 0) begin
      ew = exp_wr.pop_front();
      total++;
      if (rd_idx >= wr_n) $display("FAIL rw_write: got none expected %h", ew);
      else if (wlog[rd_idx] !== ew) $display("FAIL rw_write: got %h expected %h", wlog[rd_idx], ew);
      else passed++;
      rd_idx++;
    end
    total++;
    if (wr_n != rd_idx) $display("FAIL rw_write_count: got %0d expected %0d", wr_n, rd_idx);
    else passed++;
    rd_idx = wr_n;
  endtask

  initial begin
    rst = 1'b0;
    wb_en_in = 1'b0;
    dest_in  = 4'd0;
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    test_reset;
    test_passthrough;
    test_store;
    test_load;
    test_back_to_back;
    test_reset_mid_store;
    test_read_write_both;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
